usb_fs_in_ep_stream: RTL and testbench

- Streaming IN endpoint sitting directly upstream of the IN endpoint arbiter; one instance per bulk IN endpoint.
- Buffers application bytes in a local FIFO, packetizes them (full MAX_PKT packets, or short packets on flush/timeout) and pushes each packet into the IN protocol engine buffer via the req/grant/put/done endpoint interface.
- Waits for host ACK before starting the next packet.

---
 rtl/usb_fs_in_ep_stream.sv | 257 +++++++++++++++++++++++++
 tb/tb_usb_fs_in_ep_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_in_ep_stream.sv
`default_nettype none
// ============================================================================
//  Module      : usb_fs_in_ep_stream
//  Description : Streaming bulk IN endpoint for a full-speed USB device.
//                Application bytes are buffered in a local FIFO, cut into
//                packets (full MAX_PKT packets, or short packets on flush or
//                idle timeout) and written into the IN protocol engine buffer
//                through the req/grant/put/done endpoint interface. The next
//                packet is not started until the host has ACKed the last one.
//
//  Ports       : clk, reset            clock, synchronous active-high reset
//                app_data/valid/ready  application byte stream into the FIFO
//                app_flush             pulse: send pending partial data now
//                in_ep_req/grant       arbiter request / grant
//                in_ep_data_free       PE buffer can take a byte this cycle
//                in_ep_data_put/data   byte write strobe and byte to the PE
//                in_ep_data_done       pulse: packet complete
//                in_ep_acked           pulse: host ACKed the last packet
//
//  Options     : define USB_IN_EP_ZLP_EN to send a zero-length packet when a
//                flush finds the FIFO empty and the last packet was full.
//
//  Revision    : 1.0  initial release
// ============================================================================
module usb_fs_in_ep_stream #(
    parameter int FIFO_DEPTH    = 64,    // bytes, power of 2, >= MAX_PKT, >= 2
    parameter int MAX_PKT       = 32,    // 1..64
    parameter int FLUSH_TIMEOUT = 1024   // >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] app_data,
    input  logic       app_valid,
    output logic       app_ready,
    input  logic       app_flush,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    input  logic       in_ep_acked
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int LW = $clog2(MAX_PKT + 1);
    localparam int TW = $clog2(FLUSH_TIMEOUT);

    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXPKT_CNT = CW'(MAX_PKT);
    localparam logic [LW-1:0] MAXPKT_LEN = LW'(MAX_PKT);
    localparam logic [TW-1:0] TMO_LAST   = TW'(FLUSH_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_REQ      = 3'd1,
        S_XFER     = 3'd2,
        S_DONE     = 3'd3,
        S_WAIT_ACK = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [LW-1:0] pkt_len_q, pkt_len_d;
    logic [LW-1:0] remain_q, remain_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          flush_q, flush_d;

    logic          full;
    logic          push;
    logic          pop;
    logic          launch;
    logic          tmo_expired;

`ifdef USB_IN_EP_ZLP_EN
    logic          last_full_q, last_full_d;
`endif

    // ------------------------------------------------------------------------
    // FIFO. app_ready depends only on the registered count; a push at full is
    // still taken when a pop happens in the same cycle, so the slot freed by
    // the pop is reused without a bubble.
    // ------------------------------------------------------------------------
    assign full      = (count_q == DEPTH_C);
    assign app_ready = !full;
    assign pop       = in_ep_data_put;
    assign push      = app_valid && (!full || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= app_data;
        end
    end

    assign in_ep_data = (state_q == S_XFER) ? mem_q[rd_ptr_q] : 8'h00;

    // ------------------------------------------------------------------------
    // Idle timeout: counts only while partial data sits in IDLE.
    // ------------------------------------------------------------------------
    assign tmo_expired = (tmo_q == TMO_LAST);

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q != S_IDLE) || push || (count_q == '0)) begin
            tmo_d = '0;
        end else if (!tmo_expired) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        pkt_len_d       = pkt_len_q;
        remain_d        = remain_q;
        launch          = 1'b0;
        in_ep_req       = 1'b0;
        in_ep_data_put  = 1'b0;
        in_ep_data_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if ((count_q >= MAXPKT_CNT) ||
                    ((count_q != '0) && (flush_q || tmo_expired))) begin
                    launch  = 1'b1;
                    state_d = S_REQ;
                    if (count_q >= MAXPKT_CNT) begin
                        pkt_len_d = MAXPKT_LEN;
                        remain_d  = MAXPKT_LEN;
                    end else begin
                        // count < MAX_PKT here, so it fits the length field
                        pkt_len_d = count_q[LW-1:0];
                        remain_d  = count_q[LW-1:0];
                    end
                end
`ifdef USB_IN_EP_ZLP_EN
                else if ((count_q == '0) && last_full_q &&
                         (flush_q || app_flush)) begin
                    // Terminate a transfer that ended on a full packet
                    launch    = 1'b1;
                    state_d   = S_REQ;
                    pkt_len_d = '0;
                    remain_d  = '0;
                end
`endif
            end

            S_REQ: begin
                in_ep_req = 1'b1;
                if (in_ep_grant) begin
                    state_d = (pkt_len_q == '0) ? S_DONE : S_XFER;
                end
            end

            S_XFER: begin
                in_ep_req      = 1'b1;
                in_ep_data_put = in_ep_grant && in_ep_data_free && (remain_q != '0);
                if (in_ep_data_put) begin
                    remain_d = remain_q - LW'(1);
                    // Last byte goes out this cycle: DONE follows directly
                    if (remain_q == LW'(1)) begin
                        state_d = S_DONE;
                    end
                end else if (remain_q == '0) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                in_ep_req       = 1'b1;
                in_ep_data_done = 1'b1;
                state_d         = S_WAIT_ACK;
            end

            S_WAIT_ACK: begin
                if (in_ep_acked) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Flush request: held until IDLE either launches a packet or finds nothing
    // left to send. In IDLE with an empty FIFO any owed ZLP launches in the
    // same cycle, so an empty FIFO always retires the request.
    // ------------------------------------------------------------------------
    always_comb begin
        flush_d = flush_q || app_flush;
        if ((state_q == S_IDLE) && (launch || (count_q == '0))) begin
            flush_d = 1'b0;
        end
    end

`ifdef USB_IN_EP_ZLP_EN
    always_comb begin
        last_full_d = last_full_q;
        if ((state_q == S_WAIT_ACK) && in_ep_acked) begin
            last_full_d = (pkt_len_q == MAXPKT_LEN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_full_q <= 1'b0;
        end else begin
            last_full_q <= last_full_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            pkt_len_q <= '0;
            remain_q  <= '0;
            tmo_q     <= '0;
            flush_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pkt_len_q <= pkt_len_d;
            remain_q  <= remain_d;
            tmo_q     <= tmo_d;
            flush_q   <= flush_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_in_ep_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_usb_fs_in_ep_stream
//  Description : Self-checking bench for usb_fs_in_ep_stream. A byte queue
//                holds every accepted application byte; each packet is
//                compared against the queue head, with packet length taken
//                as min(queued bytes, MAX_PKT).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_usb_fs_in_ep_stream;

    localparam int DEPTH = 64;
    localparam int MAXP  = 32;
    localparam int FT    = 1024;
    localparam int WAIT_BOUND = 2500;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] app_data = 8'h00;
    logic       app_valid = 1'b0;
    logic       app_flush = 1'b0;
    logic       in_ep_grant = 1'b0;
    logic       in_ep_data_free = 1'b0;
    logic       in_ep_acked = 1'b0;
    logic       app_ready;
    logic       in_ep_req;
    logic       in_ep_data_put;
    logic [7:0] in_ep_data;
    logic       in_ep_data_done;

    int checks = 0;
    int errors = 0;
    int free_mode = 0;   // 0: free=1, 1: toggle, 2: random, 3: free=0

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int  level = 0;
    int  cyc = 0;
    int  dones = 0;
    int  dones_consumed = 0;
    int  done_cyc = 0;
    int  last_put_cyc = 0;
    int  first_put_cyc = 0;
    int  full_pushpop = 0;
    bit  acc_flag = 1'b0;

    usb_fs_in_ep_stream #(
        .FIFO_DEPTH    (DEPTH),
        .MAX_PKT       (MAXP),
        .FLUSH_TIMEOUT (FT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .app_data        (app_data),
        .app_valid       (app_valid),
        .app_ready       (app_ready),
        .app_flush       (app_flush),
        .in_ep_req       (in_ep_req),
        .in_ep_grant     (in_ep_grant),
        .in_ep_data_free (in_ep_data_free),
        .in_ep_data_put  (in_ep_data_put),
        .in_ep_data      (in_ep_data),
        .in_ep_data_done (in_ep_data_done),
        .in_ep_acked     (in_ep_acked)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference model: byte queue plus occupancy, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        acc_flag = 1'b0;
        if (reset) begin
            level = 0;
            exp_q.delete();
            got_q.delete();
        end else begin
            check("app_ready_vs_level", app_ready, level != DEPTH);
            if (!in_ep_req) check("data_zero_no_req", in_ep_data, 0);
            if (in_ep_data_put) begin
                check("put_needs_grant_free", in_ep_grant && in_ep_data_free, 1);
                if (got_q.size() == 0) first_put_cyc = cyc;
                got_q.push_back(in_ep_data);
                last_put_cyc = cyc;
            end
            if (in_ep_data_done) begin
                dones++;
                done_cyc = cyc;
            end
            if (app_valid && (level != DEPTH || in_ep_data_put)) begin
                if (level == DEPTH) full_pushpop++;
                exp_q.push_back(app_data);
                level++;
                acc_flag = 1'b1;
            end
            if (in_ep_data_put) level--;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        case (free_mode)
            0:       in_ep_data_free = 1'b1;
            1:       in_ep_data_free = ~in_ep_data_free;
            2:       in_ep_data_free = 1'($urandom % 2);
            default: in_ep_data_free = 1'b0;
        endcase
    endtask

    // mode 0: base+i, mode 1: random bytes
    task automatic push_n(input int n, input int mode, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            app_valid = 1'b1;
            app_data  = (mode == 0) ? 8'(base + 8'(i)) : 8'($urandom);
            tick();
        end
        app_valid = 1'b0;
    endtask

    task automatic expect_packet(input int n, input string tag, input bit b2b);
        int w;
        logic [7:0] e;
        logic [7:0] g;
        w = 0;
        while (dones == dones_consumed && w < WAIT_BOUND) begin
            tick();
            w++;
        end
        check($sformatf("%s_done_seen", tag), dones != dones_consumed, 1);
        if (dones != dones_consumed) dones_consumed++;
        check($sformatf("%s_len", tag), got_q.size(), n);
        for (int i = 0; i < n; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
            g = (i < got_q.size()) ? got_q[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), g, e);
        end
        if (n > 0) begin
            check($sformatf("%s_done_after_last_put", tag), done_cyc - last_put_cyc, 1);
            if (b2b) check($sformatf("%s_back_to_back", tag), last_put_cyc - first_put_cyc, n - 1);
        end
        got_q.delete();
        repeat (10) tick();
        check($sformatf("%s_req_low_wait_ack", tag), in_ep_req, 0);
        check($sformatf("%s_single_done", tag), dones, dones_consumed);
        in_ep_acked = 1'b1;
        tick();
        in_ep_acked = 1'b0;
    endtask

    task automatic drain(input string tag);
        app_flush = 1'b1;
        tick();
        app_flush = 1'b0;
        while (exp_q.size() > 0)
            expect_packet((exp_q.size() > MAXP) ? MAXP : exp_q.size(), tag, 1'b0);
    endtask

    initial begin
        int k;
        int acc;
        int w;
        int n;

        // Reset values
        repeat (3) tick();
        check("rst_req", in_ep_req, 0);
        check("rst_put", in_ep_data_put, 0);
        check("rst_done", in_ep_data_done, 0);
        check("rst_data", in_ep_data, 0);
        check("rst_ready", app_ready, 1);
        reset = 1'b0;
        tick();

        // Full packet 0x00..0x1F, back-to-back puts
        in_ep_grant = 1'b1;
        free_mode   = 0;
        push_n(32, 0, 8'h00);
        expect_packet(32, "full_pkt", 1'b1);

        // Short packet by timeout
        push_n(5, 0, 8'hA0);
        k = 0;
        while (!in_ep_req && k < FT + 8) begin
            tick();
            k++;
        end
        check("timeout_latency", k, FT);
        expect_packet(5, "tmo_pkt", 1'b1);

        // Short packet by flush
        push_n(5, 0, 8'hA0);
        app_flush = 1'b1;
        tick();
        app_flush = 1'b0;
        k = 1;
        while (!in_ep_req && k < 10) begin
            tick();
            k++;
        end
        check("flush_latency_le2", k <= 2, 1);
        expect_packet(5, "flush_pkt", 1'b1);

        // 40 bytes: 32 now, 8 after ack plus timeout
        push_n(40, 1, 8'h00);
        expect_packet(32, "split_a", 1'b1);
        expect_packet(8, "split_b", 1'b1);

        // Fill to full with the grant withheld, then drain with toggling free
        in_ep_grant = 1'b0;
        push_n(64, 1, 8'h00);
        check("full_ready_low", app_ready, 0);
        check("full_req_high", in_ep_req, 1);
        check("full_no_puts", got_q.size(), 0);
        in_ep_grant = 1'b1;
        free_mode   = 1;
        app_data    = 8'($urandom);
        app_valid   = 1'b1;
        acc = 0;
        w   = 0;
        while (acc < 8 && w < 200) begin
            tick();
            w++;
            if (acc_flag) begin
                acc++;
                app_data = 8'($urandom);
            end
        end
        app_valid = 1'b0;
        check("full_extra_accepted", acc, 8);
        check("full_pushpop_seen", full_pushpop > 0, 1);
        drain("full_drain");

        // Zero-length packet after a full packet
        free_mode = 0;
        push_n(32, 1, 8'h00);
        expect_packet(32, "zlp_pre", 1'b1);
        app_flush = 1'b1;
        tick();
        app_flush = 1'b0;
`ifdef USB_IN_EP_ZLP_EN
        expect_packet(0, "zlp", 1'b0);
`else
        repeat (30) tick();
        check("no_zlp_req", in_ep_req, 0);
        check("no_zlp_done", dones, dones_consumed);
`endif

        // Reset in the middle of a transfer
        free_mode       = 3;
        in_ep_data_free = 1'b0;
        push_n(32, 1, 8'h00);
        repeat (4) tick();
        check("mid_req_high", in_ep_req, 1);
        free_mode       = 0;
        in_ep_data_free = 1'b1;
        repeat (10) tick();
        free_mode       = 3;
        in_ep_data_free = 1'b0;
        check("mid_put_count", got_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("mid_byte%0d", i),
                  (i < got_q.size()) ? got_q[i] : 8'hxx,
                  (i < exp_q.size()) ? exp_q[i] : 8'hxx);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_req", in_ep_req, 0);
        check("mid_rst_put", in_ep_data_put, 0);
        check("mid_rst_done", in_ep_data_done, 0);
        check("mid_rst_ready", app_ready, 1);
        check("mid_rst_data", in_ep_data, 0);
        check("mid_rst_no_done", dones, dones_consumed);
        app_flush = 1'b1;
        tick();
        app_flush = 1'b0;
        repeat (20) tick();
        check("mid_rst_fifo_empty", in_ep_req, 0);
        free_mode = 0;
        push_n(1, 1, 8'h00);
        app_flush = 1'b1;
        tick();
        app_flush = 1'b0;
        expect_packet(1, "post_rst", 1'b1);

        // Randomized lengths, data and free pattern
        for (int it = 0; it < 6; it++) begin
            n = $urandom_range(1, 45);
            free_mode = 2;
            push_n(n, 1, 8'h00);
            drain($sformatf("rnd%0d", it));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
